// File: rtl/apb_protocol_monitor_if.sv
// apb_protocol_monitor_if: APB3 bus signal bundle shared by master, slave and passive monitor
// Signals: psel/penable/pwrite/paddr/pwdata driven by master; prdata/pready/pslverr driven by slave.
// Modports: master, slave, monitor (monitor observes everything, drives nothing).
interface apb_protocol_monitor_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 1
);
   logic [NUM_SLV-1:0] psel;
   logic               penable;
   logic               pwrite;
   logic [ADDR_W-1:0]  paddr;
   logic [DATA_W-1:0]  pwdata;
   logic [DATA_W-1:0]  prdata;
   logic               pready;
   logic               pslverr;
   modport master  (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
   modport slave   (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
   modport monitor (input psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr);
endinterface

// File: rtl/apb_protocol_monitor.sv
// apb_protocol_monitor: passive APB3 phase tracker with sticky violation flags, event pulses and debug counters
// Ports:
//   pclk, presetn  clock and async active-low reset
//   bus            APB signals, observed through the monitor modport
//   chk_en         1 = violation reporting enabled (FSM tracks regardless)
//   clr            sync clear of flags and counters (same-edge events still land)
//   err_flags      sticky violations: 0 PSEL_MULTI, 1 ENABLE_NO_SETUP, 2 SETUP_NO_ENABLE,
//                  3 UNSTABLE, 4 TIMEOUT, 5 ENABLE_DROP, 6 SLVERR
//   err_pulse      violations detected at the last edge
//   xfer_count     completed transfers, saturating
//   err_count      cycles with at least one violation, saturating
//   wait_max       worst wait-state count of any completed transfer
module apb_protocol_monitor #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 1,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16,
   localparam int WAIT_W = $clog2(TIMEOUT + 1)
) (
   input  logic                   pclk,
   input  logic                   presetn,
   apb_protocol_monitor_if.monitor bus,
   input  logic                   chk_en,
   input  logic                   clr,
   output logic [6:0]             err_flags,
   output logic [6:0]             err_pulse,
   output logic [CNT_W-1:0]       xfer_count,
   output logic [CNT_W-1:0]       err_count,
   output logic [WAIT_W-1:0]      wait_max
);
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t             state;
   logic [NUM_SLV-1:0] cap_sel;
   logic [ADDR_W-1:0]  cap_addr;
   logic               cap_write;
   logic [DATA_W-1:0]  cap_wdata;
   logic [WAIT_W-1:0]  wait_cnt;
   logic               in_acc, done, stall, tmo, unstable;
   logic [6:0]         det;
   logic [CNT_W-1:0]   xfer_base, err_base;
   logic [WAIT_W-1:0]  wmax_base;
   logic               unused_rdata;
   assign unused_rdata = ^bus.prdata;
   always_comb begin
      in_acc    = state == ACCESS;
      done      = in_acc && bus.penable && bus.pready;
      stall     = in_acc && bus.penable && !bus.pready;
      // this stall is the TIMEOUT-th wait state
      tmo       = stall && wait_cnt == WAIT_W'(TIMEOUT - 1);
      unstable  = in_acc && (cap_sel != bus.psel || cap_addr != bus.paddr || cap_write != bus.pwrite ||
                             (cap_write && cap_wdata != bus.pwdata));
      det       = {done && bus.pslverr,
                   in_acc && !bus.penable && wait_cnt != '0,
                   tmo,
                   unstable,
                   in_acc && !bus.penable && wait_cnt == '0,
                   !in_acc && bus.penable,
                   $countones(bus.psel) > 1};
      // clear first, so an event on the same edge survives the clear
      xfer_base = clr ? '0 : xfer_count;
      err_base  = clr ? '0 : err_count;
      wmax_base = clr ? '0 : wait_max;
   end
   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) begin
         state      <= IDLE;
         cap_sel    <= '0;
         cap_addr   <= '0;
         cap_write  <= 1'b0;
         cap_wdata  <= '0;
         wait_cnt   <= '0;
         err_flags  <= '0;
         err_pulse  <= '0;
         xfer_count <= '0;
         err_count  <= '0;
         wait_max   <= '0;
      end else begin
         if (!in_acc) begin
            if (|bus.psel && !bus.penable) begin
               state     <= ACCESS;
               cap_sel   <= bus.psel;
               cap_addr  <= bus.paddr;
               cap_write <= bus.pwrite;
               cap_wdata <= bus.pwdata;
               wait_cnt  <= '0;
            end
         end else if (!bus.penable || bus.pready || tmo)
            state <= IDLE;
         else
            wait_cnt <= wait_cnt + WAIT_W'(1);
         xfer_count <= xfer_base + CNT_W'(done && !(&xfer_base));
         wait_max   <= done && wait_cnt > wmax_base ? wait_cnt : wmax_base;
         if (chk_en) begin
            err_flags <= (clr ? 7'h00 : err_flags) | det;
            err_pulse <= det;
            err_count <= err_base + CNT_W'(|det && !(&err_base));
         end else if (clr) begin
            err_flags <= '0;
            err_count <= '0;
         end
      end
endmodule

// File: tb/tb_apb_protocol_monitor.sv
// tb_apb_protocol_monitor: directed self-checking bench for apb_protocol_monitor
module tb_apb_protocol_monitor;
   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        chk_en = 1'b1;
   logic        clr = 1'b0;
   logic [6:0]  err_flags, err_pulse, err_flags2, err_pulse2;
   logic [15:0] xfer_count, err_count;
   logic [1:0]  xfer_count2, err_count2;
   logic [4:0]  wait_max, wait_max2;
   int          checks = 0;
   int          fails = 0;

   apb_protocol_monitor_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4)) bus ();

   apb_protocol_monitor #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .TIMEOUT(16), .CNT_W(16)) dut (
      .pclk(pclk), .presetn(presetn), .bus(bus), .chk_en(chk_en), .clr(clr),
      .err_flags(err_flags), .err_pulse(err_pulse), .xfer_count(xfer_count),
      .err_count(err_count), .wait_max(wait_max));

   apb_protocol_monitor #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .TIMEOUT(16), .CNT_W(2)) dut_sat (
      .pclk(pclk), .presetn(presetn), .bus(bus), .chk_en(chk_en), .clr(clr),
      .err_flags(err_flags2), .err_pulse(err_pulse2), .xfer_count(xfer_count2),
      .err_count(err_count2), .wait_max(wait_max2));

   always #5 pclk = ~pclk;

   // one bus cycle: drive, let the rising edge sample it, settle 1ns past the edge
   task automatic drive(input logic [3:0] s, input logic en, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic rdy, input logic err);
      bus.psel = s; bus.penable = en; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
      bus.pready = rdy; bus.pslverr = err; bus.prdata = ~d;
      @(posedge pclk);
      #1;
   endtask

   task automatic idle();
      drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic clear();
      clr = 1'b1;
      idle();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      bus.psel = '0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
      bus.prdata = '0; bus.pready = 0; bus.pslverr = 0;
      #1;
      checks++; if (err_flags !== 7'h00) begin fails++; $display("FAIL reset_flags got %h want %h", err_flags, 7'h00); end
      checks++; if (xfer_count !== 16'd0) begin fails++; $display("FAIL reset_xfer got %0d want 0", xfer_count); end
      repeat (2) @(posedge pclk);
      #1;
      presetn = 1'b1;
      idle();
      checks++; if ({err_pulse, err_count, wait_max} !== '0) begin fails++; $display("FAIL reset_misc got %h want 0", {err_pulse, err_count, wait_max}); end
   endtask

   task automatic test_write_read();
      drive(4'b0001, 0, 1, 32'h10, 32'hA5, 0, 0);
      drive(4'b0001, 1, 1, 32'h10, 32'hA5, 1, 0);
      checks++; if (xfer_count !== 16'd1) begin fails++; $display("FAIL wr_xfer got %0d want 1", xfer_count); end
      // back-to-back: read setup on the edge right after completion; pwdata wanders but is ignored for reads
      drive(4'b0001, 0, 0, 32'h20, 32'h0, 0, 0);
      drive(4'b0001, 1, 0, 32'h20, 32'h1, 0, 0);
      drive(4'b0001, 1, 0, 32'h20, 32'h2, 0, 0);
      drive(4'b0001, 1, 0, 32'h20, 32'h3, 0, 0);
      drive(4'b0001, 1, 0, 32'h20, 32'h4, 1, 0);
      checks++; if (xfer_count !== 16'd2) begin fails++; $display("FAIL rd_xfer got %0d want 2", xfer_count); end
      checks++; if (wait_max !== 5'd3) begin fails++; $display("FAIL rd_wait_max got %0d want 3", wait_max); end
      checks++; if (err_flags !== 7'h00) begin fails++; $display("FAIL rd_flags got %h want 00", err_flags); end
   endtask

   task automatic test_enable_no_setup();
      idle();
      drive(4'b0001, 1, 0, 32'h30, 32'h0, 0, 0);
      checks++; if (err_pulse !== 7'h02) begin fails++; $display("FAIL ens_pulse got %h want 02", err_pulse); end
      checks++; if (err_flags !== 7'h02) begin fails++; $display("FAIL ens_flags got %h want 02", err_flags); end
      checks++; if (err_count !== 16'd1) begin fails++; $display("FAIL ens_count got %0d want 1", err_count); end
      idle();
      checks++; if (err_pulse !== 7'h00) begin fails++; $display("FAIL ens_pulse_drop got %h want 00", err_pulse); end
      checks++; if (err_flags !== 7'h02) begin fails++; $display("FAIL ens_sticky got %h want 02", err_flags); end
   endtask

   task automatic test_unstable();
      clear();
      checks++; if ({err_flags, err_count, xfer_count, wait_max} !== '0) begin fails++; $display("FAIL clr_all got %h want 0", {err_flags, err_count, xfer_count, wait_max}); end
      drive(4'b0001, 0, 1, 32'h10, 32'h55, 0, 0);
      drive(4'b0001, 1, 1, 32'h14, 32'h55, 0, 0);
      checks++; if (err_pulse !== 7'h08) begin fails++; $display("FAIL unst_pulse got %h want 08", err_pulse); end
      drive(4'b0001, 1, 1, 32'h14, 32'h55, 1, 0);
      checks++; if (err_flags !== 7'h08) begin fails++; $display("FAIL unst_flags got %h want 08", err_flags); end
      checks++; if (xfer_count !== 16'd1) begin fails++; $display("FAIL unst_xfer got %0d want 1", xfer_count); end
      checks++; if (err_count !== 16'd2) begin fails++; $display("FAIL unst_count got %0d want 2", err_count); end
      checks++; if (wait_max !== 5'd1) begin fails++; $display("FAIL unst_wait got %0d want 1", wait_max); end
   endtask

   task automatic test_timeout();
      clear();
      drive(4'b0001, 0, 1, 32'h40, 32'h77, 0, 0);
      repeat (15) drive(4'b0001, 1, 1, 32'h40, 32'h77, 0, 0);
      checks++; if (err_flags !== 7'h00) begin fails++; $display("FAIL tmo_early got %h want 00", err_flags); end
      drive(4'b0001, 1, 1, 32'h40, 32'h77, 0, 0);
      checks++; if (err_pulse !== 7'h10) begin fails++; $display("FAIL tmo_pulse got %h want 10", err_pulse); end
      checks++; if (xfer_count !== 16'd0) begin fails++; $display("FAIL tmo_xfer got %0d want 0", xfer_count); end
      // back in IDLE: dropping penable must not report ENABLE_DROP
      idle();
      checks++; if (err_pulse !== 7'h00) begin fails++; $display("FAIL tmo_idle got %h want 00", err_pulse); end
      drive(4'b0001, 0, 0, 32'h44, 32'h0, 0, 0);
      drive(4'b0001, 1, 0, 32'h44, 32'h0, 1, 0);
      checks++; if (xfer_count !== 16'd1 || err_flags !== 7'h10) begin fails++; $display("FAIL tmo_after got xfer=%0d flags=%h want xfer=1 flags=10", xfer_count, err_flags); end
   endtask

   task automatic test_phase_errors();
      clear();
      drive(4'b0001, 0, 0, 32'h50, 32'h0, 0, 0);
      drive(4'b0001, 0, 0, 32'h50, 32'h0, 0, 0);
      checks++; if (err_pulse !== 7'h04) begin fails++; $display("FAIL setup_no_en got %h want 04", err_pulse); end
      idle();
      drive(4'b0001, 0, 0, 32'h54, 32'h0, 0, 0);
      drive(4'b0001, 1, 0, 32'h54, 32'h0, 0, 0);
      drive(4'b0001, 0, 0, 32'h54, 32'h0, 0, 0);
      checks++; if (err_pulse !== 7'h20) begin fails++; $display("FAIL en_drop got %h want 20", err_pulse); end
      checks++; if (err_flags !== 7'h24 || err_count !== 16'd2) begin fails++; $display("FAIL phase_sum got flags=%h cnt=%0d want flags=24 cnt=2", err_flags, err_count); end
      idle();
   endtask

   task automatic test_multi_slverr_clr();
      clear();
      drive(4'b0110, 0, 1, 32'h60, 32'h1, 0, 0);
      checks++; if (err_flags !== 7'h01) begin fails++; $display("FAIL multi_flags got %h want 01", err_flags); end
      drive(4'b0110, 1, 1, 32'h60, 32'h1, 1, 0);
      drive(4'b0001, 0, 1, 32'h64, 32'h2, 0, 0);
      clr = 1'b1;
      drive(4'b0001, 1, 1, 32'h64, 32'h2, 1, 1);
      clr = 1'b0;
      checks++; if (err_flags !== 7'h40) begin fails++; $display("FAIL clr_slverr_flags got %h want 40", err_flags); end
      checks++; if (err_count !== 16'd1) begin fails++; $display("FAIL clr_slverr_count got %0d want 1", err_count); end
      checks++; if (xfer_count !== 16'd1 || err_pulse !== 7'h40) begin fails++; $display("FAIL clr_slverr_misc got xfer=%0d pulse=%h want xfer=1 pulse=40", xfer_count, err_pulse); end
   endtask

   task automatic test_chk_disable();
      chk_en = 1'b0;
      drive(4'b0001, 1, 0, 32'h70, 32'h0, 0, 0);
      checks++; if (err_flags !== 7'h40 || err_pulse !== 7'h40 || err_count !== 16'd1) begin fails++; $display("FAIL chk_frozen got flags=%h pulse=%h cnt=%0d want 40/40/1", err_flags, err_pulse, err_count); end
      idle();
      drive(4'b0001, 0, 0, 32'h70, 32'h0, 0, 0);
      drive(4'b0001, 1, 0, 32'h70, 32'h0, 0, 0);
      drive(4'b0001, 1, 0, 32'h70, 32'h0, 1, 0);
      checks++; if (xfer_count !== 16'd2 || wait_max !== 5'd1) begin fails++; $display("FAIL chk_xfer got xfer=%0d wmax=%0d want 2/1", xfer_count, wait_max); end
      chk_en = 1'b1;
      idle();
      checks++; if (err_pulse !== 7'h00) begin fails++; $display("FAIL chk_reenable got %h want 00", err_pulse); end
   endtask

   task automatic test_back_to_back_saturation();
      clear();
      for (int i = 0; i < 5; i++) begin
         drive(4'b1000, 0, 1, 32'h80 + 32'(i), 32'(i), 0, 0);
         drive(4'b1000, 1, 1, 32'h80 + 32'(i), 32'(i), 1, 0);
      end
      checks++; if (xfer_count !== 16'd5) begin fails++; $display("FAIL b2b_xfer got %0d want 5", xfer_count); end
      checks++; if (xfer_count2 !== 2'd3) begin fails++; $display("FAIL sat_xfer got %0d want 3", xfer_count2); end
      checks++; if (err_flags !== 7'h00) begin fails++; $display("FAIL b2b_flags got %h want 00", err_flags); end
      repeat (5) drive(4'b0001, 1, 0, 32'h90, 32'h0, 0, 0);
      checks++; if (err_count !== 16'd5 || err_count2 !== 2'd3) begin fails++; $display("FAIL sat_err got %0d/%0d want 5/3", err_count, err_count2); end
      idle();
   endtask

   task automatic test_reset_mid_wait();
      drive(4'b0001, 0, 1, 32'hA0, 32'h9, 0, 0);
      drive(4'b0001, 1, 1, 32'hA0, 32'h9, 0, 0);
      drive(4'b0001, 1, 1, 32'hA0, 32'h9, 0, 0);
      presetn = 1'b0;
      #2;
      checks++; if ({err_flags, err_pulse, xfer_count, err_count, wait_max} !== '0) begin fails++; $display("FAIL async_reset got %h want 0", {err_flags, err_pulse, xfer_count, err_count, wait_max}); end
      idle();
      idle();
      presetn = 1'b1;
      idle();
      drive(4'b0001, 0, 1, 32'hB0, 32'h3, 0, 0);
      drive(4'b0001, 1, 1, 32'hB0, 32'h3, 1, 0);
      checks++; if (xfer_count !== 16'd1) begin fails++; $display("FAIL rst_xfer got %0d want 1", xfer_count); end
      checks++; if (err_flags !== 7'h00 || err_count !== 16'd0) begin fails++; $display("FAIL rst_flags got flags=%h cnt=%0d want 00/0", err_flags, err_count); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_enable_no_setup();
      test_unstable();
      test_timeout();
      test_phase_errors();
      test_multi_slverr_clr();
      test_chk_disable();
      test_back_to_back_saturation();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
